// File: rtl/qed_dup_scheduler_if.sv
// Bundle of the fetch, remapper, issue and status signals of the QED
// duplicate scheduler. The slave modport is the scheduler side. The master
// modport is the side of the surrounding front end (fetch, remapper, core).
interface qed_dup_scheduler_if #(
    parameter int ADDR_W = 4
);
    logic              ena;
    logic              exec_dup;
    logic              stall;
    logic              ifu_valid;
    logic [31:0]       ifu_instruction;
    logic              ifu_ready;
    logic [31:0]       qic_qimux_instruction;
    logic [31:0]       qed_instruction;
    logic              issue_valid;
    logic [31:0]       issue_instruction;
    logic [ADDR_W:0]   occupancy;
    logic              qed_ready;
    logic              in_dup;

    modport slave (
        input  ena, exec_dup, stall, ifu_valid, ifu_instruction, qed_instruction,
        output ifu_ready, qic_qimux_instruction, issue_valid, issue_instruction,
               occupancy, qed_ready, in_dup
    );

    modport master (
        output ena, exec_dup, stall, ifu_valid, ifu_instruction, qed_instruction,
        input  ifu_ready, qic_qimux_instruction, issue_valid, issue_instruction,
               occupancy, qed_ready, in_dup
    );
endinterface

// File: rtl/qed_dup_scheduler.sv
// QED duplicate-stream scheduler.
// ORIG phase: fetched originals are issued to decode and queued in a FIFO.
// DUP phase: the FIFO is drained through the external remapper, and the
// duplicates are issued.
// Optional macro QED_STALL_ON_FULL_EN: when defined, a full FIFO holds off
// fetch and waits for exec_dup. When undefined, a full FIFO forces DUP.
module qed_dup_scheduler #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    qed_dup_scheduler_if.slave   bus
);
    typedef enum logic {
        ST_ORIG = 1'b0,
        ST_DUP  = 1'b1
    } state_t;

    localparam logic [31:0]     LP_NOP  = 32'h0000_0013;
    localparam logic [ADDR_W:0] LP_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_ONE  = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_occ;
    logic [31:0]         r_issue_instr;
    logic                r_issue_valid;
    logic                r_qed_ready;
    logic                w_full;
    logic                w_empty;
    logic                w_ifu_ready;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;

    assign w_full   = (r_occ == LP_FULL);
    assign w_empty  = (r_occ == '0);
    assign w_accept = bus.ifu_valid && w_ifu_ready;

    // Next state, fetch handshake and FIFO push/pop strobes
    always_comb begin
        w_state_nxt = r_state;
        w_ifu_ready = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            ST_ORIG: begin
                if (!bus.ena) begin
                    w_ifu_ready = !bus.stall;
                end else begin
                    w_ifu_ready = !bus.stall && !w_full && !(bus.exec_dup && !w_empty);
                end
                w_push = bus.ena && bus.ifu_valid && w_ifu_ready;
`ifdef QED_STALL_ON_FULL_EN
                if (!bus.stall && bus.ena && bus.exec_dup && !w_empty) begin
                    w_state_nxt = ST_DUP;
                end
`else
                if (!bus.stall && bus.ena && ((bus.exec_dup && !w_empty) || w_full)) begin
                    w_state_nxt = ST_DUP;
                end
`endif
            end
            ST_DUP: begin
                w_pop = !bus.stall;
                if (w_pop && (r_occ == LP_ONE)) begin
                    w_state_nxt = ST_ORIG;
                end
            end
            default: w_state_nxt = ST_ORIG;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_ORIG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage (no reset needed; validity is tracked by the pointers)
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.ifu_instruction;
        end
    end

    // FIFO pointers and occupancy; push and pop never coincide
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_occ    <= r_occ + 1'b1;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_occ    <= r_occ - 1'b1;
        end
    end

    // Issue register and the QED-consistent flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_issue_instr <= LP_NOP;
            r_issue_valid <= 1'b0;
            r_qed_ready   <= 1'b0;
        end else if (!bus.stall) begin
            if (r_state == ST_DUP) begin
                r_issue_instr <= bus.qed_instruction;
                r_issue_valid <= 1'b1;
                if (r_occ == LP_ONE) begin
                    r_qed_ready <= 1'b1;
                end
            end else if (w_accept) begin
                r_issue_instr <= bus.ifu_instruction;
                r_issue_valid <= 1'b1;
                if (bus.ena) begin
                    r_qed_ready <= 1'b0;
                end
            end else begin
                r_issue_instr <= LP_NOP;
                r_issue_valid <= 1'b0;
            end
        end
    end

    assign bus.ifu_ready             = w_ifu_ready;
    assign bus.qic_qimux_instruction = r_mem[r_rd_ptr];
    assign bus.issue_valid           = r_issue_valid;
    assign bus.issue_instruction     = r_issue_instr;
    assign bus.occupancy             = r_occ;
    assign bus.qed_ready             = r_qed_ready;
    assign bus.in_dup                = (r_state == ST_DUP);
endmodule
